// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-client ALU arbiter.
// The operation struct is sized by ALU_W, which must match the arbiter's N.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int ALU_W = 8;

    typedef struct packed {
        logic [1:0]       f;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             id;
    } alu_op_t;

endpackage

// File: rtl/alu_share_arbiter_gen_alu.sv
// Combinational N-bit ALU: add, subtract, and, or.
// SUB computes a + ~b + 1, so co=1 means no borrow; logic ops clear co.
module gen_alu
    import alu_share_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]   f_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    logic [N:0] res;

    always_comb begin
        res = '0;
        unique case (f_i)
            ALU_ADD: res = {1'b0, a_i} + {1'b0, b_i};
            ALU_SUB: res = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
            ALU_AND: res = {1'b0, a_i & b_i};
            ALU_OR:  res = {1'b0, a_i | b_i};
            default: res = '0;
        endcase
    end

    assign s_o  = res[N-1:0];
    assign co_o = res[N];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one gen_alu between two valid/ready requesters.
// One op in flight: accept in IDLE, compute in EXEC, hold the tagged result in RESP.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_f,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_f,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_s,
    output logic         rsp_co
);

    arb_state_t   state_q, state_d;
    alu_op_t      op_q;
    logic         last_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [N-1:0] rsp_s_q;
    logic         rsp_co_q;

    logic         win_id;
    logic         accept;
    logic [N-1:0] alu_s;
    logic         alu_co;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        win_id     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept && !win_id;
        req1_ready = accept && win_id;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_s_q     <= '0;
            rsp_co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q.f  <= win_id ? req1_f : req0_f;
                op_q.a  <= win_id ? req1_a : req0_a;
                op_q.b  <= win_id ? req1_b : req0_b;
                op_q.id <= win_id;
                last_q  <= win_id;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= op_q.id;
                rsp_s_q     <= alu_s;
                rsp_co_q    <= alu_co;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    gen_alu #(.N(N)) u_alu (
        .f_i  (op_q.f),
        .a_i  (op_q.a),
        .b_i  (op_q.b),
        .s_o  (alu_s),
        .co_o (alu_co)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_co    = rsp_co_q;

    a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE) |-> !(req0_ready || req1_ready));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected results queued at accept,
// popped by a monitor on every response handshake.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_f = '0, req1_f = '0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp_valid, rsp_id, rsp_co;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_s;

    typedef struct {
        logic         id;
        logic [N-1:0] s;
        logic         co;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_f(req0_f), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_f(req1_f), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // view is exactly what the next edge will act on.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d s=%0h co=%0d, expected no response",
                         rsp_id, rsp_s, rsp_co);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
                chk("rsp_s",  {24'd0, rsp_s},  {24'd0, mon_e.s});
                chk("rsp_co", {31'd0, rsp_co}, {31'd0, mon_e.co});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input bit eco, input bit push);
        bit done = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_f = f; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_f = f; req0_a = a; req0_b = b; end
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                if (push) q.push_back('{id, es, eco});
                done = 1'b1;
            end
            cyc();
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: requester %0d got no ready, expected a grant", id);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 30) begin cyc(); n++; end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin cyc(); n++; end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        cyc(); rst = 1'b1;
        cyc(); cyc(); rst = 1'b0;
    endtask

    initial begin
        int got;

        // Reset with both requesters pending
        cyc(); rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0_c1", {31'd0, req0_ready}, 0);
        chk("rst_ready1_c1", {31'd0, req1_ready}, 0);
        cyc(); #1;
        chk("rst_ready0", {31'd0, req0_ready}, 0);
        chk("rst_ready1", {31'd0, req1_ready}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_s", {24'd0, rsp_s}, 0);
        chk("rst_rsp_co", {31'd0, rsp_co}, 0);
        cyc(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;

        // Single op with carry out; latency T -> T+2
        issue(1'b0, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        #1;
        chk("lat_t1_rsp_valid", {31'd0, rsp_valid}, 0);
        cyc(); #1;
        chk("lat_t2_rsp_valid", {31'd0, rsp_valid}, 1);
        chk("lat_t2_rsp_s", {24'd0, rsp_s}, 32'h00);
        chk("lat_t2_rsp_co", {31'd0, rsp_co}, 1);
        drain();

        // Contention: alternate 0,1,0,1 starting from a fresh reset
        do_reset();
        req0_f = ALU_ADD; req0_a = 8'd3;  req0_b = 8'd4;
        req1_f = ALU_ADD; req1_a = 8'd10; req1_b = 8'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("grant_order", {31'd0, req1_ready}, got % 2);
                chk("grant_onehot", {31'd0, req0_ready & req1_ready}, 0);
                if (got % 2 == 1) q.push_back('{1'b1, 8'd15, 1'b0});
                else              q.push_back('{1'b0, 8'd7,  1'b0});
                got++;
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contention_grants", got, 4);
        drain();

        // Backpressure: result held 5 cycles with both requesters waiting
        rsp_ready = 1'b0;
        issue(1'b0, ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1);
        wait_rsp();
        req0_f = ALU_ADD; req0_a = 8'd3;    req0_b = 8'd4;
        req1_f = ALU_OR;  req1_a = 8'h0F;   req1_b = 8'h50;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_rsp_s", {24'd0, rsp_s}, 32'h30);
            chk("bp_rsp_id", {31'd0, rsp_id}, 0);
            chk("bp_ready_none", {30'd0, req1_ready, req0_ready}, 0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc(); #1;
        chk("bp_resume_req1", {31'd0, req1_ready}, 1);
        chk("bp_resume_req0", {31'd0, req0_ready}, 0);
        q.push_back('{1'b1, 8'h5F, 1'b0});
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Reset while in EXEC: op dropped, req0 wins the next tie
        issue(1'b1, ALU_ADD, 8'd9, 8'd4, 8'd13, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 0);
            cyc();
        end
        req1_f = ALU_ADD; req1_a = 8'd10; req1_b = 8'd5; req1_valid = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("rstmid_tie_req0", {31'd0, req0_ready}, 1);
        chk("rstmid_tie_req1", {31'd0, req1_ready}, 0);
        issue(1'b0, ALU_ADD, 8'd3, 8'd4, 8'd7, 1'b0, 1'b1);
        req1_valid = 1'b0;
        drain();

        // Withdraw: req1 pulses valid for one cycle while a result is held
        rsp_ready = 1'b0;
        issue(1'b0, ALU_ADD, 8'd1, 8'd2, 8'd3, 1'b0, 1'b1);
        wait_rsp();
        cyc();
        req1_f = ALU_ADD; req1_a = 8'd10; req1_b = 8'd5; req1_valid = 1'b1;
        #1;
        chk("wd_req1_ready", {31'd0, req1_ready}, 0);
        cyc(); req1_valid = 1'b0;
        cyc(); rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        drain();
        chk("hold_rsp_s", {24'd0, rsp_s}, 32'h03);
        chk("hold_rsp_id", {31'd0, rsp_id}, 0);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
